// File: rtl/uart_frame_parser.sv
// Frame parser for 0x55 0xAA LEN payload CSUM command frames from the UART receiver.
// Payload is buffered and only released on the cmd stream once the checksum matches.
module uart_frame_parser #(
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] rx_data,
  input  logic       rx_en,
  output logic [7:0] cmd_data,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       cmd_last,
  output logic [7:0] cmd_len,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR2, S_LEN, S_DATA, S_CSUM, S_OUT
  } state_t;

  state_t      state_q, state_d;
  logic        rx_en_d_q;
  logic [7:0]  len_q, len_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  wr_ptr_q, wr_ptr_d;
  logic [7:0]  rd_ptr_q, rd_ptr_d;
  logic [15:0] tmo_q, tmo_d;
  logic        frame_ok_q, frame_ok_d;
  logic        frame_err_q, frame_err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [7:0]  mem_q [MAX_LEN];
  logic        mem_we;
  logic        strobe;
  logic        counting;
  logic        timeout;
  logic        in_out;
  logic        last;

  assign strobe   = rx_en & ~rx_en_d_q;
  assign counting = (state_q == S_HDR2) || (state_q == S_LEN) ||
                    (state_q == S_DATA) || (state_q == S_CSUM);
  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign timeout  = counting && !strobe && (tmo_q == 16'(TIMEOUT_CYC - 1));
  assign in_out   = (state_q == S_OUT);
  assign last     = in_out && (rd_ptr_q == len_q - 8'd1);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    csum_d      = csum_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    mem_we      = 1'b0;
    tmo_d       = (counting && !strobe && !timeout) ? tmo_q + 16'd1 : '0;

    case (state_q)
      S_IDLE: if (strobe && rx_data == 8'h55) state_d = S_HDR2;
      S_HDR2: if (strobe) begin
        if (rx_data == 8'hAA)      state_d = S_LEN;
        else if (rx_data != 8'h55) state_d = S_IDLE;
      end
      S_LEN: if (strobe) begin
        if (rx_data != 8'd0 && rx_data <= 8'(MAX_LEN)) begin
          len_d    = rx_data;
          csum_d   = rx_data;
          wr_ptr_d = '0;
          state_d  = S_DATA;
        end else begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
          err_code_d  = 2'd1;
        end
      end
      S_DATA: if (strobe) begin
        mem_we   = 1'b1;
        csum_d   = csum_q + rx_data;
        wr_ptr_d = wr_ptr_q + 8'd1;
        if (wr_ptr_q == len_q - 8'd1) state_d = S_CSUM;
      end
      S_CSUM: if (strobe) begin
        if (rx_data == csum_q) begin
          state_d    = S_OUT;
          frame_ok_d = 1'b1;
          rd_ptr_d   = '0;
        end else begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
          err_code_d  = 2'd2;
        end
      end
      S_OUT: if (cmd_ready) begin
        if (last) state_d = S_IDLE;
        else      rd_ptr_d = rd_ptr_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout) begin
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
      err_code_d  = 2'd3;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      rx_en_d_q   <= 1'b0;
      len_q       <= '0;
      csum_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tmo_q       <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      rx_en_d_q   <= rx_en;
      len_q       <= len_d;
      csum_q      <= csum_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tmo_q       <= tmo_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q[AW-1:0]] <= rx_data;
  end

  // Payload outputs are gated so they read 0 outside a drain, including straight after reset.
  assign cmd_valid = in_out;
  assign cmd_data  = in_out ? mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign cmd_last  = last;
  assign cmd_len   = in_out ? len_q : '0;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: table of whole frames with a payload scoreboard,
// plus hand sequences for reset, timeout recovery and reset during drain.
module tb_uart_frame_parser;

  localparam int unsigned MAXL = 16;
  localparam int unsigned TMO  = 1000;
  localparam int          NV   = 7;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] rx_data;
  logic       rx_en;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_last;
  logic [7:0] cmd_len;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  uart_frame_parser #(.MAX_LEN(MAXL), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_en(rx_en),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_last(cmd_last), .cmd_len(cmd_len), .frame_ok(frame_ok),
    .frame_err(frame_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [191:0] b;
    int           n;
    int           hold;
    int           rmode;
    int           exp_ok;
    int           exp_err;
    logic [1:0]   exp_code;
    logic [127:0] pl;
    int           npl;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       last;
    logic [7:0] len;
  } exp_t;

  vec_t       vecs [NV];
  exp_t       sb [$];
  int         checks = 0;
  int         errors = 0;
  int         ok_cnt = 0;
  int         err_cnt = 0;
  logic [1:0] last_code = '0;
  int         rmode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    rx_data = b;
    rx_en   = 1'b1;
    repeat (hold) @(posedge clk);
    #1 rx_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && !cmd_valid) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic last, input logic [7:0] len);
    exp_t e;
    e.d = d; e.last = last; e.len = len;
    sb.push_back(e);
  endtask

  initial begin
    int ok0, err0, cyc;
    bit seen, okwin;

    vecs[0] = '{56'h55AA0311223369, 7, 1, 0, 1, 0, 2'd0, 128'h112233, 3};
    vecs[1] = '{56'h55AA0311223369, 7, 1, 1, 1, 0, 2'd0, 128'h112233, 3};
    vecs[2] = '{48'h55AA02FF0200, 6, 1, 0, 0, 1, 2'd2, 128'h0, 0};
    vecs[3] = '{48'h55AA0055AA11, 6, 1, 0, 0, 2, 2'd1, 128'h0, 0};
    vecs[4] = '{56'h135555AA01A5A6, 7, 400, 0, 1, 0, 2'd0, 128'hA5, 1};
    vecs[5] = '{160'h55AA10_000102030405060708090A0B0C0D0E0F_88, 20, 1, 1, 1, 0, 2'd0,
                128'h000102030405060708090A0B0C0D0E0F, 16};
    vecs[6] = '{48'h55AA02FF0203, 6, 1, 0, 1, 0, 2'd0, 128'hFF02, 2};

    rstn = 1'b0; rx_en = 1'b0; rx_data = '0; cmd_ready = 1'b1;

    fork
      forever begin
        @(posedge clk);
        #1;
        cmd_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ~cmd_ready : 1'b0;
      end
      begin : monitor
        bit         pstall = 0;
        logic [7:0] pd = '0, plen = '0;
        logic       plast = 0;
        exp_t       e;
        forever begin
          @(negedge clk);
          if (!rstn) begin
            pstall = 0;
          end else begin
            if (frame_ok) ok_cnt++;
            if (frame_err) begin
              err_cnt++;
              last_code = err_code;
            end
            if (pstall && cmd_valid) begin
              chk("stall_data_held", {24'd0, cmd_data}, {24'd0, pd});
              chk("stall_last_held", {31'd0, cmd_last}, {31'd0, plast});
              chk("stall_len_held", {24'd0, cmd_len}, {24'd0, plen});
            end
            if (cmd_valid && cmd_ready) begin
              if (sb.size() == 0) begin
                chk("unexpected_transfer", {24'd0, cmd_data}, 32'hFFFF_FFFF);
              end else begin
                e = sb.pop_front();
                chk("cmd_data", {24'd0, cmd_data}, {24'd0, e.d});
                chk("cmd_last", {31'd0, cmd_last}, {31'd0, e.last});
                chk("cmd_len", {24'd0, cmd_len}, {24'd0, e.len});
              end
            end
            pstall = cmd_valid && !cmd_ready;
            pd = cmd_data; plast = cmd_last; plen = cmd_len;
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_valid", {31'd0, cmd_valid}, 0);
    chk("rst_cmd_data", {24'd0, cmd_data}, 0);
    chk("rst_cmd_last", {31'd0, cmd_last}, 0);
    chk("rst_cmd_len", {24'd0, cmd_len}, 0);
    chk("rst_frame_ok", {31'd0, frame_ok}, 0);
    chk("rst_frame_err", {31'd0, frame_err}, 0);
    chk("rst_err_code", {30'd0, err_code}, 0);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int v = 0; v < NV; v++) begin
      rmode = vecs[v].rmode;
      for (int j = 0; j < vecs[v].npl; j++)
        push_exp(vecs[v].pl[8*(vecs[v].npl-1-j) +: 8], j == vecs[v].npl - 1, 8'(vecs[v].npl));
      ok0 = ok_cnt;
      err0 = err_cnt;
      for (int i = 0; i < vecs[v].n; i++)
        send_byte(vecs[v].b[8*(vecs[v].n-1-i) +: 8], vecs[v].hold);
      wait_drain();
      chk($sformatf("vec%0d_frame_ok", v), ok_cnt - ok0, vecs[v].exp_ok);
      chk($sformatf("vec%0d_frame_err", v), err_cnt - err0, vecs[v].exp_err);
      if (vecs[v].exp_err > 0)
        chk($sformatf("vec%0d_err_code", v), {30'd0, last_code}, {30'd0, vecs[v].exp_code});
    end

    // Inter-byte timeout, then recovery with a fresh frame.
    rmode = 0;
    err0 = err_cnt;
    send_byte(8'h55, 1); send_byte(8'hAA, 1); send_byte(8'h02, 1); send_byte(8'h10, 1);
    seen = 0; cyc = 0;
    for (int c = 0; c < int'(TMO) + 50; c++) begin
      @(negedge clk);
      if (err_cnt > err0) begin
        seen = 1; cyc = c;
        break;
      end
    end
    okwin = seen && cyc >= int'(TMO) - 30 && cyc <= int'(TMO) + 5;
    chk("tmo_err_seen", {31'd0, seen}, 1);
    chk("tmo_latency_window", {31'd0, okwin}, 1);
    chk("tmo_err_count", err_cnt - err0, 1);
    chk("tmo_err_code", {30'd0, err_code}, 3);
    @(posedge clk);
    #1;
    ok0 = ok_cnt;
    push_exp(8'h7E, 1'b1, 8'd1);
    send_byte(8'h55, 1); send_byte(8'hAA, 1); send_byte(8'h01, 1);
    send_byte(8'h7E, 1); send_byte(8'h7F, 1);
    wait_drain();
    chk("tmo_recover_ok", ok_cnt - ok0, 1);
    chk("err_code_sticky", {30'd0, err_code}, 3);

    // Reset asserted while a frame waits on a stalled consumer.
    rmode = 2;
    @(posedge clk);
    #1;
    send_byte(8'h55, 1); send_byte(8'hAA, 1); send_byte(8'h01, 1);
    send_byte(8'hA5, 1); send_byte(8'hA6, 1);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (cmd_valid) begin
        seen = 1;
        break;
      end
    end
    chk("drain_valid_seen", {31'd0, seen}, 1);
    chk("drain_data_a5", {24'd0, cmd_data}, 32'hA5);
    #2 rstn = 1'b0;
    #1;
    chk("rst_drain_valid", {31'd0, cmd_valid}, 0);
    chk("rst_drain_data", {24'd0, cmd_data}, 0);
    chk("rst_drain_last", {31'd0, cmd_last}, 0);
    chk("rst_drain_code", {30'd0, err_code}, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_idle", {31'd0, cmd_valid}, 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
